lv_efuse_loader: RTL and testbench

//  Responder side of the LV efuse load handshake: on i_efuse_load_req it reads EFUSE_WORD_NUM words

---
 rtl/lv_efuse_loader.sv | 146 ++++++++++++++
 tb/tb_lv_efuse_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lv_efuse_loader.sv
// LV efuse loader: reads EFUSE_WORD_NUM words from the efuse macro, mirrors them into the LV
// register bank and qualifies the image. Optional CRC-8 check over the image: LV_EFUSE_CRC_EN.
module lv_efuse_loader #(
  parameter int                  EFUSE_WORD_NUM = 8,
  parameter int                  EFUSE_DW       = 8,
  parameter int                  EFUSE_AW       = 3,
  parameter int                  RD_WAIT_CYC    = 4,
  parameter logic [EFUSE_AW-1:0] REG_BASE_ADDR  = '0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_efuse_load_req,
  output logic                o_efuse_load_done,
  output logic                o_efuse_vld,
  output logic                o_efuse_busy,
  output logic                o_efuse_rd_en,
  output logic [EFUSE_AW-1:0] o_efuse_addr,
  input  logic [EFUSE_DW-1:0] i_efuse_rdata,
  output logic                o_efuse_reg_wr_en,
  output logic [EFUSE_AW-1:0] o_efuse_reg_addr,
  output logic [EFUSE_DW-1:0] o_efuse_reg_wdata
);

  localparam int WW = (RD_WAIT_CYC > 1) ? $clog2(RD_WAIT_CYC) : 1;
  localparam logic [EFUSE_AW-1:0] LAST_WORD = EFUSE_AW'(EFUSE_WORD_NUM - 1);
  localparam logic [WW-1:0]       LAST_WAIT = WW'(RD_WAIT_CYC - 1);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, CHK, DONE, REL} state_t;

  state_t              state_q, state_d;
  logic [EFUSE_AW-1:0] cnt_q, cnt_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [EFUSE_DW-1:0] wdata_q, wdata_d;
  logic                marker_q, marker_d;
  logic                vld_q, vld_d;

`ifdef LV_EFUSE_CRC_EN
  logic [7:0] crc_q, crc_d;

  // CRC-8, poly 0x07, MSB first, one whole byte per call
  function automatic logic [7:0] crc8Step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      wdata_q  <= '0;
      marker_q <= 1'b0;
      vld_q    <= 1'b0;
`ifdef LV_EFUSE_CRC_EN
      crc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      wdata_q  <= wdata_d;
      marker_q <= marker_d;
      vld_q    <= vld_d;
`ifdef LV_EFUSE_CRC_EN
      crc_q    <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    wdata_d  = wdata_q;
    marker_d = marker_q;
    vld_d    = vld_q;
`ifdef LV_EFUSE_CRC_EN
    crc_d    = crc_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_efuse_load_req) begin
          state_d = RD;
          cnt_d   = '0;
          vld_d   = 1'b0;
`ifdef LV_EFUSE_CRC_EN
          crc_d   = '0;
`endif
        end
      end
      RD: begin
        state_d = WAIT;
        wait_d  = '0;
      end
      WAIT: begin
        if (wait_q == LAST_WAIT) begin
          wdata_d = i_efuse_rdata;
          if (cnt_q == '0) marker_d = i_efuse_rdata[EFUSE_DW-1];
          state_d = WR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WR: begin
        if (cnt_q == LAST_WORD) begin
          state_d = CHK;
        end else begin
`ifdef LV_EFUSE_CRC_EN
          crc_d   = crc8Step(crc_q, wdata_q[7:0]);
`endif
          cnt_d   = cnt_q + 1'b1;
          state_d = RD;
        end
      end
      CHK: begin
        // wdata_q still holds the last word here, which is the stored CRC
`ifdef LV_EFUSE_CRC_EN
        vld_d   = marker_q & (crc_q == wdata_q[7:0]);
`else
        vld_d   = marker_q;
`endif
        state_d = DONE;
      end
      DONE: state_d = REL;
      REL: begin
        if (!i_efuse_load_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_efuse_rd_en     = (state_q == RD);
  assign o_efuse_addr      = o_efuse_rd_en ? cnt_q : '0;
  assign o_efuse_reg_wr_en = (state_q == WR);
  assign o_efuse_reg_addr  = o_efuse_reg_wr_en ? (cnt_q + REG_BASE_ADDR) : '0;
  assign o_efuse_reg_wdata = o_efuse_reg_wr_en ? wdata_q : '0;
  assign o_efuse_load_done = (state_q == DONE);
  assign o_efuse_busy      = (state_q != IDLE) && (state_q != REL);
  assign o_efuse_vld       = vld_q;

endmodule

// File: tb/tb_lv_efuse_loader.sv
// Directed self-checking bench for lv_efuse_loader with a behavioural efuse macro model.
// Expectations follow the build: LV_EFUSE_CRC_EN selects the CRC-qualified checks.
module tb_lv_efuse_loader;
  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic          req;
  logic [DW-1:0] rdata;
  logic          done, vld, busy, rdEn, wrEn;
  logic [AW-1:0] addr, regAddr;
  logic [DW-1:0] wdata;

  int testsRun  = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  lv_efuse_loader #(
    .EFUSE_WORD_NUM(N), .EFUSE_DW(DW), .EFUSE_AW(AW), .RD_WAIT_CYC(RW), .REG_BASE_ADDR(3'd0)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_efuse_load_req(req),
    .o_efuse_load_done(done), .o_efuse_vld(vld), .o_efuse_busy(busy),
    .o_efuse_rd_en(rdEn), .o_efuse_addr(addr), .i_efuse_rdata(rdata),
    .o_efuse_reg_wr_en(wrEn), .o_efuse_reg_addr(regAddr), .o_efuse_reg_wdata(wdata)
  );

  // Efuse macro model: data is only valid in the last wait cycle, poison value otherwise
  logic [DW-1:0] mem [N];
  logic [AW-1:0] rdAddr;
  int            waitCnt;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      waitCnt <= 0;
      rdAddr  <= '0;
    end else if (rdEn) begin
      rdAddr  <= addr;
      waitCnt <= 1;
    end else if (waitCnt > 0 && waitCnt <= RW) begin
      waitCnt <= waitCnt + 1;
    end
  end

  assign rdata = (waitCnt == RW) ? mem[rdAddr] : 8'hA5;

  // Transaction monitor, sampling 1 time unit after each rising edge
  int            cyc = 0;
  int            startCyc = 0;
  int            rdCount, wrCount, doneCount, doneRel;
  int            preVld, vldRel1, doneVld, doneBusy;
  int            rdRel [32];
  logic [AW-1:0] rdAddrLog [32];
  int            wrRel [32];
  logic [AW-1:0] wrAddrLog [32];
  logic [DW-1:0] wrDataLog [32];

  always @(posedge clk) begin : monitor
    int rel;
    #1;
    cyc++;
    rel = cyc - startCyc;
    if (rdEn && rdCount < 32) begin
      rdRel[rdCount]     = rel;
      rdAddrLog[rdCount] = addr;
      rdCount++;
    end
    if (wrEn && wrCount < 32) begin
      wrRel[wrCount]     = rel;
      wrAddrLog[wrCount] = regAddr;
      wrDataLog[wrCount] = wdata;
      wrCount++;
    end
    if (done) begin
      if (doneCount == 0) begin
        doneRel  = rel;
        doneVld  = int'(vld);
        doneBusy = int'(busy);
      end
      doneCount++;
    end
    if (rel == 1)  vldRel1 = int'(vld);
    if (rel == 49) preVld  = int'(vld);
  end

  // Bit-serial reference CRC-8 (poly 0x07, init 0) over words 0..N-2
  function automatic logic [7:0] refCrc();
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int w = 0; w < N - 1; w++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ mem[w][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  function automatic int expVld();
    logic q;
    q = mem[0][DW-1];
`ifdef LV_EFUSE_CRC_EN
    q = q & (refCrc() == mem[N-1]);
`endif
    return int'(q);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearLog();
    rdCount = 0; wrCount = 0; doneCount = 0; doneRel = -1;
    preVld = -1; vldRel1 = -1; doneVld = -1; doneBusy = -1;
  endtask

  task automatic loadWords(input logic [DW-1:0] w0);
    mem[0] = w0;
    for (int i = 1; i < N; i++) mem[i] = DW'(8'h10 + i);
  endtask

  // Raise req at a falling edge; optionally drop it after dropAt cycles; wait for done
  task automatic applyStimulus(input int dropAt);
    int n;
    n = 0;
    clearLog();
    req      = 1'b1;
    startCyc = cyc;
    while (doneCount == 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (n == dropAt) req = 1'b0;
    end
    checkOutput("doneSeen", doneCount, 1);
  endtask

  task automatic releaseReq();
    req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] allOutputs();
    return 32'({done, vld, busy, rdEn, addr, wrEn, regAddr, wdata});
  endfunction

  initial begin
    rstN = 1'b0;
    req  = 1'b0;
    loadWords(8'h80);
    clearLog();
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", allOutputs(), 0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal load, full transaction trace
    applyStimulus(-1);
    checkOutput("t1DoneCycle", doneRel, 50);
    checkOutput("t1RdCount", rdCount, N);
    checkOutput("t1WrCount", wrCount, N);
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("t1RdAddr%0d", k), rdAddrLog[k], k);
      checkOutput($sformatf("t1RdCyc%0d", k), rdRel[k], 1 + 6 * k);
      checkOutput($sformatf("t1WrAddr%0d", k), wrAddrLog[k], k);
      checkOutput($sformatf("t1WrData%0d", k), wrDataLog[k], mem[k]);
      checkOutput($sformatf("t1WrCyc%0d", k), wrRel[k], 6 + 6 * k);
    end
    checkOutput("t1PreDoneVld", preVld, 0);
    checkOutput("t1DoneVld", doneVld, expVld());
    checkOutput("t1DoneBusy", doneBusy, 1);
    releaseReq();
    checkOutput("t1IdleBusy", busy, 0);
    checkOutput("t1VldHold", vld, expVld());
    checkOutput("t1DonePulse", doneCount, 1);

    // Unprogrammed marker
    loadWords(8'h00);
    applyStimulus(-1);
    checkOutput("t2DoneCycle", doneRel, 50);
    checkOutput("t2VldCleared", vldRel1, 0);
    checkOutput("t2DoneVld", doneVld, 0);
    releaseReq();
    checkOutput("t2VldHold", vld, 0);

    // Marker programmed again, then req held high long after done
    loadWords(8'h80);
    applyStimulus(-1);
    checkOutput("t3PreDoneVld", preVld, 0);
    checkOutput("t3DoneVld", doneVld, expVld());
    repeat (20) @(negedge clk);
    checkOutput("t3HoldRdCount", rdCount, N);
    checkOutput("t3HoldBusy", busy, 0);
    checkOutput("t3HoldDoneCount", doneCount, 1);
    req = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(-1);
    checkOutput("t3SecondDone", doneRel, 50);
    checkOutput("t3SecondRdCount", rdCount, N);
    releaseReq();

    // Reset asserted in cycle 25 of a load
    clearLog();
    req      = 1'b1;
    startCyc = cyc;
    repeat (25) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("t4ResetOutputs", allOutputs(), 0);
    checkOutput("t4RdBeforeRst", rdCount, 5);
    checkOutput("t4WrBeforeRst", wrCount, 4);
    req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t4RdDuringRst", rdCount, 5);
    checkOutput("t4WrDuringRst", wrCount, 4);
    rstN = 1'b1;
    @(negedge clk);
    applyStimulus(-1);
    checkOutput("t4RestartAddr", rdAddrLog[0], 0);
    checkOutput("t4RestartCyc", rdRel[0], 1);
    checkOutput("t4DoneCycle", doneRel, 50);
    checkOutput("t4RdCount", rdCount, N);
    releaseReq();

    // Req dropped at cycle 10
    applyStimulus(10);
    checkOutput("t5DoneCycle", doneRel, 50);
    checkOutput("t5RdCount", rdCount, N);
    repeat (4) @(negedge clk);
    checkOutput("t5IdleBusy", busy, 0);
    checkOutput("t5NoRestart", rdCount, N);

`ifdef LV_EFUSE_CRC_EN
    // Golden CRC in word 7, then a single bit error in word 3
    loadWords(8'h80);
    mem[N-1] = refCrc();
    applyStimulus(-1);
    checkOutput("t6CrcDoneVld", doneVld, 1);
    checkOutput("t6CrcWord7", wrDataLog[N-1], mem[N-1]);
    releaseReq();
    mem[3] = mem[3] ^ 8'h04;
    applyStimulus(-1);
    checkOutput("t6CrcBadVld", doneVld, 0);
    checkOutput("t6CrcBadDone", doneRel, 50);
    releaseReq();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
